// File: rtl/flit_rx_monitor_pkg.sv
// Shared definitions for the flit receive monitor: flit type codes, field
// positions, error codes, parameter defaults and a saturating adder.
package flit_rx_monitor_pkg;

    localparam int DATAW_DEF = 66;
    localparam int VCHW_DEF  = 1;
    localparam int LENW_DEF  = 16;

    // Type field occupies the two MSBs: [DATAW-1:DATAW-2].
    localparam int TYPEW       = 2;
    localparam int TYPE_HI_OFS = 1;   // DATAW - TYPE_HI_OFS is the type MSB
    localparam int TYPE_LO_OFS = 2;   // DATAW - TYPE_LO_OFS is the type LSB
    localparam int DSTW        = 32;  // destination lives in [31:0] of a HEAD

    typedef enum logic [TYPEW-1:0] {
        TYPE_NONE = 2'b00,
        TYPE_HEAD = 2'b01,
        TYPE_TAIL = 2'b10,
        TYPE_DATA = 2'b11
    } flit_type_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } rx_state_e;

    localparam logic [1:0] ERR_NONE        = 2'd0;
    localparam logic [1:0] ERR_ORPHAN      = 2'd1;
    localparam logic [1:0] ERR_NESTED_HEAD = 2'd2;
    localparam logic [1:0] ERR_VCH         = 2'd3;

    // 32-bit add that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/flit_popcount.sv
// Combinational population count of a flit-wide vector (7-bit result).
module flit_popcount #(
    parameter int DATAW = 66
) (
    input  logic [DATAW-1:0] vec_i,
    output logic [6:0]       count_o
);

    // Sum of set bits; a plain adder chain that synthesis rebalances.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < DATAW; i++) begin
            count_o = count_o + 7'(vec_i[i]);
        end
    end

endmodule

// File: rtl/flit_rx_monitor.sv
// Sink for a router output port: parses HEAD/DATA/TAIL framing, reports
// completed packets, flags framing/VC errors and keeps statistics counters.
// Optional FLIT_TOGGLE_EN adds the bit-toggle (Hamming distance) counter;
// without it toggle_cnt is tied to zero and no previous-flit state exists.
//
// Interface: ivalid high means idata/ivch carry a flit that is consumed in
// that cycle. There is no ready/backpressure; every valid cycle is taken.
module flit_rx_monitor
    import flit_rx_monitor_pkg::*;
#(
    parameter int DATAW = DATAW_DEF,
    parameter int VCHW  = VCHW_DEF,
    parameter int LENW  = LENW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DATAW-1:0] idata,
    input  logic             ivalid,
    input  logic [VCHW-1:0]  ivch,
    input  logic             clr,
    output logic             busy,
    output logic             pkt_done,
    output logic [LENW-1:0]  pkt_len,
    output logic [DSTW-1:0]  pkt_dst,
    output logic [VCHW-1:0]  pkt_vch,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [31:0]      flit_cnt,
    output logic [31:0]      pkt_cnt,
    output logic [31:0]      toggle_cnt
);

    flit_type_e ftype;
    assign ftype = flit_type_e'(idata[DATAW-TYPE_HI_OFS:DATAW-TYPE_LO_OFS]);

    rx_state_e       state_q, state_d;
    logic [LENW-1:0] len_q, len_d;
    logic [DSTW-1:0] dst_q, dst_d;
    logic [VCHW-1:0] vch_q, vch_d;

    logic            pkt_done_q, pkt_done_d;
    logic [LENW-1:0] pkt_len_q, pkt_len_d;
    logic [DSTW-1:0] pkt_dst_q, pkt_dst_d;
    logic [VCHW-1:0] pkt_vch_q, pkt_vch_d;
    logic            err_q, err_d;
    logic [1:0]      err_code_q, err_code_d;
    logic [31:0]     flit_cnt_q, pkt_cnt_q;

    // Next-state and registered-output decode for the framing FSM.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        dst_d      = dst_q;
        vch_d      = vch_q;
        pkt_done_d = 1'b0;
        pkt_len_d  = pkt_len_q;
        pkt_dst_d  = pkt_dst_q;
        pkt_vch_d  = pkt_vch_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        if (ivalid) begin
            case (state_q)
                ST_IDLE: begin
                    case (ftype)
                        TYPE_HEAD: begin
                            dst_d   = idata[DSTW-1:0];
                            vch_d   = ivch;
                            len_d   = '0;
                            state_d = ST_BODY;
                        end
                        TYPE_DATA, TYPE_TAIL: begin
                            err_d      = 1'b1;
                            err_code_d = ERR_ORPHAN;
                        end
                        default: ;
                    endcase
                end
                ST_BODY: begin
                    // VC check first so a nested HEAD below overrides its code.
                    if (ivch != vch_q) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_VCH;
                    end
                    case (ftype)
                        TYPE_HEAD: begin
                            err_d      = 1'b1;
                            err_code_d = ERR_NESTED_HEAD;
                            dst_d      = idata[DSTW-1:0];
                            vch_d      = ivch;
                            len_d      = '0;
                        end
                        TYPE_DATA: begin
                            if (len_q != '1) len_d = len_q + LENW'(1);
                        end
                        TYPE_TAIL: begin
                            pkt_done_d = 1'b1;
                            pkt_len_d  = len_q;
                            pkt_dst_d  = dst_q;
                            pkt_vch_d  = vch_q;
                            state_d    = ST_IDLE;
                        end
                        default: ;
                    endcase
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM, packet outputs and flit/packet counters; clr only touches counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            dst_q      <= '0;
            vch_q      <= '0;
            pkt_done_q <= 1'b0;
            pkt_len_q  <= '0;
            pkt_dst_q  <= '0;
            pkt_vch_q  <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            flit_cnt_q <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            dst_q      <= dst_d;
            vch_q      <= vch_d;
            pkt_done_q <= pkt_done_d;
            pkt_len_q  <= pkt_len_d;
            pkt_dst_q  <= pkt_dst_d;
            pkt_vch_q  <= pkt_vch_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            if (clr) begin
                flit_cnt_q <= '0;
                pkt_cnt_q  <= '0;
            end else begin
                if (ivalid)     flit_cnt_q <= sat_add32(flit_cnt_q, 32'd1);
                if (pkt_done_d) pkt_cnt_q  <= sat_add32(pkt_cnt_q, 32'd1);
            end
        end
    end

`ifdef FLIT_TOGGLE_EN
    logic [DATAW-1:0] prev_flit_q;
    logic [31:0]      toggle_cnt_q;
    logic [6:0]       toggle_inc;

    flit_popcount #(.DATAW(DATAW)) u_popcount (
        .vec_i   (idata ^ prev_flit_q),
        .count_o (toggle_inc)
    );

    // Hamming distance between consecutive valid flits, accumulated.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            prev_flit_q  <= '0;
            toggle_cnt_q <= '0;
        end else if (ivalid) begin
            prev_flit_q  <= idata;
            toggle_cnt_q <= sat_add32(toggle_cnt_q, 32'(toggle_inc));
        end
    end

    assign toggle_cnt = toggle_cnt_q;
`else
    // Payload above the destination field only feeds the toggle counter.
    logic unused_payload;
    assign unused_payload = ^idata[DATAW-TYPE_LO_OFS-1:DSTW];
    assign toggle_cnt     = '0;
`endif

    // busy is the FSM state itself.
    assign busy     = (state_q == ST_BODY);
    assign pkt_done = pkt_done_q;
    assign pkt_len  = pkt_len_q;
    assign pkt_dst  = pkt_dst_q;
    assign pkt_vch  = pkt_vch_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign flit_cnt = flit_cnt_q;
    assign pkt_cnt  = pkt_cnt_q;

endmodule

// File: tb/tb_flit_rx_monitor.sv
// Self-checking bench for flit_rx_monitor: a table of single-cycle vectors
// with hand-computed results, then hand-written multi-cycle sequences.
// Toggle expectations depend on whether FLIT_TOGGLE_EN is defined.
module tb_flit_rx_monitor;

    localparam logic [1:0] T_NONE = 2'b00;
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_DATA = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic [65:0] idata;
    logic        ivalid;
    logic [0:0]  ivch;
    logic        clr;
    logic        busy, pkt_done, err;
    logic [15:0] pkt_len;
    logic [31:0] pkt_dst;
    logic [0:0]  pkt_vch;
    logic [1:0]  err_code;
    logic [31:0] flit_cnt, pkt_cnt, toggle_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    // scoreboard: {dst, len, vch} of each expected completed packet
    logic [48:0] exp_q[$];

    // bench-side toggle model
    logic [65:0] prev_m;
    logic [31:0] tog_m;

    flit_rx_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .idata      (idata),
        .ivalid     (ivalid),
        .ivch       (ivch),
        .clr        (clr),
        .busy       (busy),
        .pkt_done   (pkt_done),
        .pkt_len    (pkt_len),
        .pkt_dst    (pkt_dst),
        .pkt_vch    (pkt_vch),
        .err        (err),
        .err_code   (err_code),
        .flit_cnt   (flit_cnt),
        .pkt_cnt    (pkt_cnt),
        .toggle_cnt (toggle_cnt)
    );

    // clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle, sample #1 after the edge, then update model/scoreboard.
    task automatic step(input logic r, input logic c, input logic v, input logic [1:0] typ,
                        input logic [63:0] payload, input logic [0:0] vc);
        logic [48:0] e;
        rst    = r;
        clr    = c;
        ivalid = v;
        idata  = {typ, payload};
        ivch   = vc;
        @(posedge clk);
        #1;
        if (r || c) begin
            prev_m = '0;
            tog_m  = '0;
        end else if (v) begin
            tog_m  = tog_m + 32'($countones(idata ^ prev_m));
            prev_m = idata;
        end
`ifdef FLIT_TOGGLE_EN
        chk("toggle_cnt", 64'(toggle_cnt), 64'(tog_m));
`else
        chk("toggle_cnt_tied", 64'(toggle_cnt), 64'd0);
`endif
        if (pkt_done) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_done", 64'(pkt_done), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_packet", 64'({pkt_dst, pkt_len, pkt_vch}), 64'(e));
            end
        end
    endtask

    typedef struct {
        logic        r, c, v;
        logic [1:0]  typ;
        logic [31:0] dst;
        logic [0:0]  vc;
        logic        busy, done, err;
        logic [1:0]  code;
        logic [15:0] len;
        logic [31:0] pdst;
        logic [0:0]  pvch;
        logic [31:0] fc, pc;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic c, input logic v, input logic [1:0] typ,
                                input logic [31:0] dst, input logic [0:0] vc,
                                input logic b, input logic d, input logic e, input logic [1:0] code,
                                input logic [15:0] len, input logic [31:0] pdst, input logic [0:0] pvch,
                                input logic [31:0] fc, input logic [31:0] pc);
        vec_t t;
        t.r = r; t.c = c; t.v = v; t.typ = typ; t.dst = dst; t.vc = vc;
        t.busy = b; t.done = d; t.err = e; t.code = code; t.len = len;
        t.pdst = pdst; t.pvch = pvch; t.fc = fc; t.pc = pc;
        return t;
    endfunction

    vec_t vecs[20];

    initial begin
        rst = 1'b1; clr = 1'b0; ivalid = 1'b0; idata = '0; ivch = '0;
        prev_m = '0; tog_m = '0;

        //             r  c  v  typ     dst          vc  busy done err code len pdst   pvch fc  pc
        vecs[0]  = mk(1, 0, 0, T_NONE, 32'h0,   0,  0, 0, 0, 0, 0, 32'h0,  0, 0,  0);
        vecs[1]  = mk(0, 0, 1, T_DATA, 32'h0,   0,  0, 0, 1, 1, 0, 32'h0,  0, 1,  0);
        vecs[2]  = mk(0, 0, 1, T_NONE, 32'h0,   0,  0, 0, 0, 1, 0, 32'h0,  0, 2,  0);
        vecs[3]  = mk(0, 0, 1, T_HEAD, 32'hA5,  1,  1, 0, 0, 1, 0, 32'h0,  0, 3,  0);
        vecs[4]  = mk(0, 0, 1, T_DATA, 32'h0,   1,  1, 0, 0, 1, 0, 32'h0,  0, 4,  0);
        vecs[5]  = mk(0, 0, 0, T_DATA, 32'h0,   0,  1, 0, 0, 1, 0, 32'h0,  0, 4,  0);
        vecs[6]  = mk(0, 0, 1, T_DATA, 32'h0,   1,  1, 0, 0, 1, 0, 32'h0,  0, 5,  0);
        vecs[7]  = mk(0, 0, 1, T_NONE, 32'h0,   1,  1, 0, 0, 1, 0, 32'h0,  0, 6,  0);
        vecs[8]  = mk(0, 0, 1, T_TAIL, 32'h0,   1,  0, 1, 0, 1, 2, 32'hA5, 1, 7,  1);
        vecs[9]  = mk(0, 0, 1, T_HEAD, 32'h33,  0,  1, 0, 0, 1, 2, 32'hA5, 1, 8,  1);
        vecs[10] = mk(0, 0, 1, T_HEAD, 32'h44,  1,  1, 0, 1, 2, 2, 32'hA5, 1, 9,  1);
        vecs[11] = mk(0, 0, 1, T_DATA, 32'h0,   0,  1, 0, 1, 3, 2, 32'hA5, 1, 10, 1);
        vecs[12] = mk(0, 0, 1, T_DATA, 32'h0,   1,  1, 0, 0, 3, 2, 32'hA5, 1, 11, 1);
        vecs[13] = mk(0, 1, 1, T_TAIL, 32'h0,   1,  0, 1, 0, 3, 2, 32'h44, 1, 0,  0);
        vecs[14] = mk(0, 0, 1, T_DATA, 32'h0,   0,  0, 0, 1, 1, 2, 32'h44, 1, 1,  0);
        vecs[15] = mk(0, 0, 1, T_HEAD, 32'h77,  0,  1, 0, 0, 1, 2, 32'h44, 1, 2,  0);
        vecs[16] = mk(0, 0, 1, T_DATA, 32'h0,   0,  1, 0, 0, 1, 2, 32'h44, 1, 3,  0);
        vecs[17] = mk(1, 0, 1, T_DATA, 32'h0,   0,  0, 0, 0, 0, 0, 32'h0,  0, 0,  0);
        vecs[18] = mk(0, 0, 1, T_TAIL, 32'h0,   0,  0, 0, 1, 1, 0, 32'h0,  0, 1,  0);
        vecs[19] = mk(0, 0, 0, T_NONE, 32'h0,   0,  0, 0, 0, 1, 0, 32'h0,  0, 1,  0);

        // table-driven vectors
        for (int i = 0; i < 20; i++) begin
            if (vecs[i].done) exp_q.push_back({vecs[i].pdst, vecs[i].len, vecs[i].pvch});
            step(vecs[i].r, vecs[i].c, vecs[i].v, vecs[i].typ, {32'h0, vecs[i].dst}, vecs[i].vc);
            chk($sformatf("row%0d_busy", i),     64'(busy),     64'(vecs[i].busy));
            chk($sformatf("row%0d_pkt_done", i), 64'(pkt_done), 64'(vecs[i].done));
            chk($sformatf("row%0d_err", i),      64'(err),      64'(vecs[i].err));
            chk($sformatf("row%0d_err_code", i), 64'(err_code), 64'(vecs[i].code));
            chk($sformatf("row%0d_pkt_len", i),  64'(pkt_len),  64'(vecs[i].len));
            chk($sformatf("row%0d_pkt_dst", i),  64'(pkt_dst),  64'(vecs[i].pdst));
            chk($sformatf("row%0d_pkt_vch", i),  64'(pkt_vch),  64'(vecs[i].pvch));
            chk($sformatf("row%0d_flit_cnt", i), 64'(flit_cnt), 64'(vecs[i].fc));
            chk($sformatf("row%0d_pkt_cnt", i),  64'(pkt_cnt),  64'(vecs[i].pc));
        end

        // normal packet: HEAD dst=9, 20 DATA, TAIL back to back
        step(1, 0, 0, T_NONE, 64'h0, 0);
        step(0, 0, 1, T_HEAD, 64'h9, 0);
        chk("norm_head_err", 64'(err), 64'd0);
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 1, T_DATA, {$urandom, $urandom}, 0);
            chk("norm_data_err", 64'(err), 64'd0);
            chk("norm_data_done", 64'(pkt_done), 64'd0);
        end
        exp_q.push_back({32'd9, 16'd20, 1'b0});
        step(0, 0, 1, T_TAIL, 64'h0, 0);
        chk("norm_done", 64'(pkt_done), 64'd1);
        chk("norm_len", 64'(pkt_len), 64'd20);
        chk("norm_dst", 64'(pkt_dst), 64'd9);
        chk("norm_vch", 64'(pkt_vch), 64'd0);
        chk("norm_pkt_cnt", 64'(pkt_cnt), 64'd1);
        chk("norm_flit_cnt", 64'(flit_cnt), 64'd22);
        chk("norm_err", 64'(err), 64'd0);
        chk("norm_busy", 64'(busy), 64'd0);
        step(0, 0, 0, T_NONE, 64'h0, 0);
        chk("norm_done_pulse", 64'(pkt_done), 64'd0);

        // nested HEAD: HEAD, HEAD, 3 DATA, TAIL
        step(0, 0, 1, T_HEAD, 64'h12, 0);
        step(0, 0, 1, T_HEAD, 64'h34, 0);
        chk("nest_err", 64'(err), 64'd1);
        chk("nest_code", 64'(err_code), 64'd2);
        chk("nest_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, T_DATA, 64'h0, 0);
        exp_q.push_back({32'h34, 16'd3, 1'b0});
        step(0, 0, 1, T_TAIL, 64'h0, 0);
        chk("nest_done", 64'(pkt_done), 64'd1);
        chk("nest_len", 64'(pkt_len), 64'd3);
        chk("nest_pkt_cnt", 64'(pkt_cnt), 64'd2);

        // clr: counters zero, packet outputs kept
        step(0, 1, 0, T_NONE, 64'h0, 0);
        chk("clr_flit_cnt", 64'(flit_cnt), 64'd0);
        chk("clr_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("clr_pkt_len", 64'(pkt_len), 64'd3);
        chk("clr_pkt_dst", 64'(pkt_dst), 64'h34);

        // idle gaps inside a packet on VC 1
        step(0, 0, 1, T_HEAD, 64'h55, 1);
        step(0, 0, 1, T_DATA, 64'h0, 1);
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 0, T_DATA, 64'hDEAD, 0);
            chk("gap_flit_cnt", 64'(flit_cnt), 64'd2);
            chk("gap_pkt_len", 64'(pkt_len), 64'd3);
            chk("gap_busy", 64'(busy), 64'd1);
            chk("gap_err", 64'(err), 64'd0);
        end
        step(0, 0, 1, T_DATA, 64'h0, 1);
        exp_q.push_back({32'h55, 16'd2, 1'b1});
        step(0, 0, 1, T_TAIL, 64'h0, 1);
        chk("gap_done", 64'(pkt_done), 64'd1);
        chk("gap_len", 64'(pkt_len), 64'd2);
        chk("gap_vch", 64'(pkt_vch), 64'd1);
        chk("gap_flit_total", 64'(flit_cnt), 64'd4);

        // VC change mid-packet: error, packet still completes
        step(0, 0, 1, T_HEAD, 64'h66, 0);
        step(0, 0, 1, T_DATA, 64'h0, 1);
        chk("vc_err", 64'(err), 64'd1);
        chk("vc_code", 64'(err_code), 64'd3);
        exp_q.push_back({32'h66, 16'd1, 1'b0});
        step(0, 0, 1, T_TAIL, 64'h0, 0);
        chk("vc_done", 64'(pkt_done), 64'd1);
        chk("vc_len", 64'(pkt_len), 64'd1);

        // toggle count from reset: HEAD(dst 0)=1, DATA 0=1, DATA ones=64
        step(1, 0, 0, T_NONE, 64'h0, 0);
        step(0, 0, 1, T_HEAD, 64'h0, 0);
        step(0, 0, 1, T_DATA, 64'h0, 0);
        step(0, 0, 1, T_DATA, 64'hFFFF_FFFF_FFFF_FFFF, 0);
`ifdef FLIT_TOGGLE_EN
        chk("toggle_hand", 64'(toggle_cnt), 64'd66);
`else
        chk("toggle_hand", 64'(toggle_cnt), 64'd0);
`endif
        step(0, 1, 0, T_NONE, 64'h0, 0);
        chk("toggle_clr", 64'(toggle_cnt), 64'd0);
        chk("toggle_clr_busy", 64'(busy), 64'd1);

        // reset mid-packet: HEAD + 5 DATA, then rst, then orphan TAIL
        step(1, 0, 0, T_NONE, 64'h0, 0);
        step(0, 0, 1, T_HEAD, 64'h88, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 1, T_DATA, 64'h0, 1);
        step(1, 0, 0, T_NONE, 64'h0, 0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(pkt_done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_code", 64'(err_code), 64'd0);
        chk("rst_len", 64'(pkt_len), 64'd0);
        chk("rst_dst", 64'(pkt_dst), 64'd0);
        chk("rst_vch", 64'(pkt_vch), 64'd0);
        chk("rst_flit_cnt", 64'(flit_cnt), 64'd0);
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        step(0, 0, 1, T_TAIL, 64'h0, 0);
        chk("rst_orphan_err", 64'(err), 64'd1);
        chk("rst_orphan_code", 64'(err_code), 64'd1);
        chk("rst_orphan_busy", 64'(busy), 64'd0);
        chk("rst_orphan_done", 64'(pkt_done), 64'd0);

        chk("sb_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
